// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

   // Controller states: waiting for operands, iterating digits, holding the product.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Three overlapping multiplier bits {b[2i+1], b[2i], b[2i-1]}.
   typedef logic [2:0] booth_code_t;

   // Decoded Booth digit: zero selects nothing, two_x selects 2A, neg subtracts.
   typedef struct packed {
      logic zero;
      logic two_x;
      logic neg;
   } booth_digit_t;

   // Number of radix-4 digits needed to cover a WIDTH+2 bit extended multiplier.
   function automatic int digit_count(input int width);
      return width / 2 + 1;
   endfunction

   // Standard radix-4 recoding table.
   function automatic booth_digit_t booth_decode(input booth_code_t code);
      booth_digit_t d;
      d = '{zero: 1'b0, two_x: 1'b0, neg: 1'b0};
      case (code)
         3'b000, 3'b111: d.zero  = 1'b1;
         3'b001, 3'b010: d.zero  = 1'b0;
         3'b011:         d.two_x = 1'b1;
         3'b100:         d = '{zero: 1'b0, two_x: 1'b1, neg: 1'b1};
         default:        d.neg   = 1'b1;   // 101, 110 -> -A
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/product handshake bundle for booth_seq_mult.
interface booth_seq_mult_if #(
   parameter int WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_signed;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;

   // Requester side: presents operands and consumes products.
   modport master (
      output in_valid, in_signed, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_signed, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/booth_pp_sel.sv
// Radix-4 partial-product selector: returns 0, A or 2A as a magnitude plus a negate flag.
module booth_pp_sel
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  booth_code_t        code,
   input  logic [WIDTH+1:0]   a,
   output logic [WIDTH+2:0]   mag,
   output logic               neg
);

   booth_digit_t digit;

   assign digit = booth_decode(code);
   assign neg   = digit.neg;

   // Choose 0, sign-extended A, or A shifted left by one.
   always_comb begin
      mag = '0;
      if (!digit.zero) begin
         if (digit.two_x) mag = {a, 1'b0};
         else             mag = {a[WIDTH+1], a};
      end
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   booth_seq_mult_if.slave bus
);

   localparam int N    = digit_count(WIDTH);
   localparam int CW   = $clog2(N) + 1;
   localparam int AW   = WIDTH + 2;       // extended operand width
   localparam int MW   = WIDTH + 3;       // selected magnitude width (room for 2A)
   localparam int ACCW = 2 * WIDTH + 4;   // accumulator width

   state_t             state_reg, state_next;
   logic [AW-1:0]      a_reg;
   logic [AW-1:0]      b_sh_reg;          // multiplier, shifted right two bits per digit
   logic               bm1_reg;           // bit just below the current digit pair
   logic [CW-1:0]      cnt_reg;
   logic [ACCW-1:0]    acc_reg;

   logic [AW-1:0]      a_ext, b_ext;
   logic [MW-1:0]      pp_mag;
   logic               pp_neg;
   logic [ACCW-1:0]    pp_wide, pp_shifted, addend, acc_next;
   logic               last_digit;

   // Extend operands by two bits so every radix-4 digit sees a proper sign.
   assign a_ext = {{2{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
   assign b_ext = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b};

   assign last_digit = (cnt_reg == CW'(N - 1));

   booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
      .code (booth_code_t'({b_sh_reg[1], b_sh_reg[0], bm1_reg})),
      .a    (a_reg),
      .mag  (pp_mag),
      .neg  (pp_neg)
   );

   // Weight the digit by 4^i; subtraction is ~x plus a carry-in of one.
   assign pp_wide    = {{(ACCW-MW){pp_mag[MW-1]}}, pp_mag};
   assign pp_shifted = pp_wide << {cnt_reg, 1'b0};
   assign addend     = pp_shifted ^ {ACCW{pp_neg}};
   assign acc_next   = acc_reg + addend + {{(ACCW-1){1'b0}}, pp_neg};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.in_valid)  state_next = CALC;
         CALC:    if (last_digit)    state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the registered state.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_reg)
         IDLE:    bus.in_ready  = 1'b1;
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.out_p = acc_reg[2*WIDTH-1:0];

   // Operand latch, digit iteration and accumulation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_sh_reg <= '0;
         bm1_reg  <= 1'b0;
         cnt_reg  <= '0;
         acc_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg    <= a_ext;
                  b_sh_reg <= b_ext;
                  bm1_reg  <= 1'b0;
                  cnt_reg  <= '0;
                  acc_reg  <= '0;
               end
            end
            CALC: begin
               acc_reg  <= acc_next;
               b_sh_reg <= {{2{b_sh_reg[AW-1]}}, b_sh_reg[AW-1:2]};
               bm1_reg  <= b_sh_reg[1];
               cnt_reg  <= cnt_reg + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench: directed WIDTH=8 cases and randomized WIDTH=16 traffic.
module tb_booth_seq_mult;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   booth_seq_mult_if #(.WIDTH(8))  if8 ();
   booth_seq_mult_if #(.WIDTH(16)) if16 ();

   booth_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   booth_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   // Compare, count, and report a miscompare.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product of the interpreted operands, truncated to 2w bits.
   function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit sgn);
      longint ax, bx, p;
      logic [63:0] mask;
      ax = longint'({32'b0, a});
      bx = longint'({32'b0, b});
      if (sgn && a[w-1]) ax = ax - (longint'(1) << w);
      if (sgn && b[w-1]) bx = bx - (longint'(1) << w);
      p    = ax * bx;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   // One full WIDTH=8 transaction; entered and left at #1 after a rising edge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                      input logic [15:0] exp, input string tag);
      int lat;
      int guard;
      guard = 0;
      while (!if8.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      if8.in_a = a; if8.in_b = b; if8.in_signed = sgn; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_signed = 1'($urandom);
      lat = 0;
      while (!if8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check({tag, "_lat"}, 64'(lat), 64'd5);
      check({tag, "_p"}, 64'(if8.out_p), 64'(exp));
      $display("w8 %s a=%h b=%h s=%0d p=%h lat=%0d", tag, a, b, sgn, if8.out_p, lat);
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
      check({tag, "_rdy"}, 64'(if8.in_ready), 64'd1);
   endtask

   // One WIDTH=16 transaction with random input and output gaps.
   task automatic op16(input int idx);
      logic [15:0] a, b;
      bit          sgn;
      logic [63:0] exp;
      int          lat, gap;
      a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
      exp = ref_prod(16, 32'(a), 32'(b), sgn);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      check("w16_rdy", 64'(if16.in_ready), 64'd1);
      if16.in_a = a; if16.in_b = b; if16.in_signed = sgn; if16.in_valid = 1'b1;
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      if16.in_a = 16'($urandom); if16.in_b = 16'($urandom); if16.in_signed = 1'($urandom);
      lat = 0;
      while (!if16.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check("w16_lat", 64'(lat), 64'd9);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      check("w16_p", 64'(if16.out_p), exp);
      $display("w16 #%0d a=%h b=%h s=%0d p=%h exp=%h lat=%0d", idx, a, b, sgn,
               if16.out_p, exp[31:0], lat);
      if16.out_ready = 1'b1;
      @(posedge clk); #1;
      if16.out_ready = 1'b0;
   endtask

   // Hard time limit so the run can never hang.
   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] exp;
      int          lat;
      logic [15:0] held;

      rst_n = 1'b0;
      if8.in_valid = 1'b0;  if8.in_signed = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.out_ready = 1'b0;
      if16.in_valid = 1'b0; if16.in_signed = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(if8.in_ready), 64'd1);
      check("rst_out_valid", 64'(if8.out_valid), 64'd0);
      check("rst_out_p", 64'(if8.out_p), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed WIDTH=8 products.
      op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_m128");
      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255_255");
      op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_m1");
      op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_1");
      op8(8'h00, 8'hB3, 1'b1, 16'h0000, "s_0_m77");
      op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_127_m128");

      // Back-pressure: product held for 10 cycles while a new request is ignored.
      exp = ref_prod(8, 32'h5A, 32'hC3, 1'b1);
      if8.in_a = 8'h5A; if8.in_b = 8'hC3; if8.in_signed = 1'b1; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_a = 8'h11; if8.in_b = 8'h22;
      lat = 0;
      while (!if8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check("bp_lat", 64'(lat), 64'd5);
      held = if8.out_p;
      for (int i = 0; i < 10; i++) begin
         check("bp_p", 64'(if8.out_p), exp);
         check("bp_in_ready", 64'(if8.in_ready), 64'd0);
         check("bp_out_valid", 64'(if8.out_valid), 64'd1);
         @(posedge clk); #1;
      end
      $display("w8 backpressure p=%h exp=%h", held, exp[15:0]);
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
      check("bp_release_rdy", 64'(if8.in_ready), 64'd1);
      check("bp_release_valid", 64'(if8.out_valid), 64'd0);

      // Reset during the third CALC cycle aborts the operation.
      if8.in_a = 8'h37; if8.in_b = 8'h6D; if8.in_signed = 1'b0; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_in_ready", 64'(if8.in_ready), 64'd1);
      check("abort_out_valid", 64'(if8.out_valid), 64'd0);
      check("abort_out_p", 64'(if8.out_p), 64'd0);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         if (if8.out_valid) lat++;
         @(posedge clk); #1;
      end
      check("abort_no_stale", 64'(lat), 64'd0);
      $display("w8 reset abort stale_cycles=%0d", lat);
      op8(8'hA7, 8'h3C, 1'b1, 16'(ref_prod(8, 32'hA7, 32'h3C, 1'b1)), "post_rst_s");
      op8(8'hA7, 8'h3C, 1'b0, 16'(ref_prod(8, 32'hA7, 32'h3C, 1'b0)), "post_rst_u");

      // Randomized WIDTH=16 traffic.
      for (int i = 0; i < 2000; i++) op16(i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
